// File: rtl/display_scan_controller_pkg.sv
// Shared constants and the scan phase type for the six-digit display scanner.
package display_pkg;
  localparam int NUM_DIGITS_DEFAULT = 6;
  localparam int BCD_MAX            = 9;
  localparam int DP_MIN_UNITS_IDX   = 2;
  localparam int DP_HR_UNITS_IDX    = 4;
  localparam int HOURS_TENS_IDX     = 5;
  localparam logic [31:0] ANODE_OFF = '1;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;
endpackage

// File: rtl/display_scan_controller_scan_timer.sv
// Slot timer: one counter spans a whole slot (blank then drive), idx wraps per frame.
// state is brought out so checkers can observe the phase directly.
module scan_timer
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = NUM_DIGITS_DEFAULT,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int IDX_W        = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output scan_state_t      state,
  output scan_state_t      state_next,
  output logic [IDX_W-1:0] idx_next,
  output logic             slot_start,
  output logic             frame_end
);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt, cnt_next;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
    end
  end

  // slot_start: the coming edge enters BLANK of slot idx_next (also every disabled cycle).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    slot_start = 1'b0;
    frame_end  = 1'b0;
    if (!enable) begin
      state_next = BLANK;
      cnt_next   = '0;
      idx_next   = '0;
      slot_start = 1'b1;
    end else begin
      case (state)
        BLANK: begin
          cnt_next = cnt + 1'b1;
          if (cnt == BLANK_LAST) state_next = DRIVE;
        end
        DRIVE: begin
          if (cnt == SLOT_LAST) begin
            cnt_next   = '0;
            state_next = BLANK;
            slot_start = 1'b1;
            frame_end  = (idx == IDX_LAST);
            idx_next   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: state_next = BLANK;
      endcase
    end
  end
endmodule

// File: rtl/display_scan_controller.sv
// Six-digit BCD display scanner with blanking and frame-aligned double buffering.
// Optional LEADING_ZERO_BLANK_EN suppresses a zero hours-tens digit.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = NUM_DIGITS_DEFAULT,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    dp_en,
  output logic                    load_ack,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [3:0]              bcd_out,
  output logic                    dp,
  output logic                    bcd_err
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  scan_state_t             state, state_next;
  logic [IDX_W-1:0]        idx_next;
  logic                    slot_start, frame_end;
  logic [4*NUM_DIGITS-1:0] staging, shadow, shadow_next;
  logic                    pending, transfer;
  logic [3:0]              digit;
  logic                    digit_bad, lz_suppress;
  logic                    slot_show, slot_bad;
  logic [NUM_DIGITS-1:0]   an_next;
  logic                    dp_next;

  scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .IDX_W       (IDX_W),
    .CNT_W       (CNT_W)
  ) u_scan_timer (
    .clk       (clk),
    .rst       (reset),
    .enable    (enable),
    .state     (state),
    .state_next(state_next),
    .idx_next  (idx_next),
    .slot_start(slot_start),
    .frame_end (frame_end)
  );

  // Handshake: load is a fire-and-forget strobe (no ready); staged data is committed
  // only at a frame boundary, and load_ack pulses once on the cycle after that commit.
  assign transfer = frame_end && (pending || load);

  always_comb begin
    shadow_next = shadow;
    if (transfer) shadow_next = load ? digits_in : staging;
    digit     = shadow_next[4*idx_next +: 4];
    digit_bad = digit > 4'(BCD_MAX);
`ifdef LEADING_ZERO_BLANK_EN
    lz_suppress = (idx_next == IDX_W'(HOURS_TENS_IDX)) && (digit == 4'd0);
`else
    lz_suppress = 1'b0;
`endif
    an_next = ANODE_OFF[NUM_DIGITS-1:0];
    if (state_next == DRIVE && slot_show) an_next[idx_next] = 1'b0;
    dp_next = ~(dp_en && state_next == DRIVE &&
                (idx_next == IDX_W'(DP_MIN_UNITS_IDX) || idx_next == IDX_W'(DP_HR_UNITS_IDX)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staging   <= '0;
      shadow    <= '0;
      pending   <= 1'b0;
      load_ack  <= 1'b0;
      an        <= ANODE_OFF[NUM_DIGITS-1:0];
      bcd_out   <= 4'd0;
      dp        <= 1'b1;
      bcd_err   <= 1'b0;
      slot_show <= 1'b1;
      slot_bad  <= 1'b0;
    end else begin
      if (load) staging <= digits_in;
      if (transfer) pending <= 1'b0;
      else if (load) pending <= 1'b1;
      shadow   <= shadow_next;
      load_ack <= transfer;
      // The slot's digit is latched on entry to BLANK so it is stable through DRIVE.
      if (slot_start) begin
        bcd_out   <= digit_bad ? 4'd0 : digit;
        slot_bad  <= digit_bad;
        slot_show <= !digit_bad && !lz_suppress;
      end
      if (state == BLANK && state_next == DRIVE && slot_bad) bcd_err <= 1'b1;
      an <= an_next;
      dp <= dp_next;
    end
  end
endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: reference model indexed by cycles since scan start.
module tb_display_scan_controller;
  localparam int N     = 6;
  localparam int R     = 8;
  localparam int B     = 2;
  localparam int FRAME = N * R;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, enable, load, dp_en;
  logic [23:0] digits_in;
  logic        load_ack, dp, bcd_err;
  logic [5:0]  an;
  logic [3:0]  bcd_out;

  display_scan_controller #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .load     (load),
    .digits_in(digits_in),
    .dp_en    (dp_en),
    .load_ack (load_ack),
    .an       (an),
    .bcd_out  (bcd_out),
    .dp       (dp),
    .bcd_err  (bcd_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model state: k = cycles since scan (re)start.
  int          k;
  logic [23:0] m_shadow, m_stage;
  bit          m_pend, m_err, m_show, m_bad;
  logic [3:0]  m_bcd;
  int          ack_seen;

  task automatic model_reset();
    k = 0; m_shadow = '0; m_stage = '0; m_pend = 0; m_err = 0;
    m_show = 1; m_bad = 0; m_bcd = 4'd0;
  endtask

  task automatic step();
    int slot, p;
    logic [3:0] d;
    logic [5:0] exp_an;
    logic exp_dp, exp_ack;
    @(posedge clk);
    exp_ack = 1'b0;
    if (load) begin m_stage = digits_in; m_pend = 1; end
    if (!enable) k = 0;
    else begin
      k++;
      if (k % FRAME == 0 && m_pend) begin m_shadow = m_stage; m_pend = 0; exp_ack = 1'b1; end
    end
    slot = (k / R) % N;
    p = k % R;
    if (p == 0) begin
      d = m_shadow[4*slot +: 4];
      m_bad  = d > 4'd9;
      m_show = !m_bad && !(LZB && slot == 5 && d == 4'd0);
      m_bcd  = m_bad ? 4'd0 : d;
    end
    if (enable && p == B && m_bad) m_err = 1;
    exp_an = 6'h3F;
    if (enable && p >= B && m_show) exp_an[slot] = 1'b0;
    exp_dp = !(dp_en && enable && p >= B && (slot == 2 || slot == 4));
    #1;
    checks++;
    if (an !== exp_an) begin fails++; $display("FAIL an k=%0d got %b want %b", k, an, exp_an); end
    if (enable) begin
      checks++;
      if (bcd_out !== m_bcd) begin fails++; $display("FAIL bcd_out k=%0d got %0d want %0d", k, bcd_out, m_bcd); end
    end
    checks++;
    if (dp !== exp_dp) begin fails++; $display("FAIL dp k=%0d got %b want %b", k, dp, exp_dp); end
    checks++;
    if (load_ack !== exp_ack) begin fails++; $display("FAIL load_ack k=%0d got %b want %b", k, load_ack, exp_ack); end
    checks++;
    if (bcd_err !== m_err) begin fails++; $display("FAIL bcd_err k=%0d got %b want %b", k, bcd_err, m_err); end
    if (load_ack === 1'b1) ack_seen++;
  endtask

  task automatic align(input int pos);
    for (int i = 0; i < 2 * FRAME && (k % FRAME) != pos; i++) step();
    checks++;
    if ((k % FRAME) != pos) begin fails++; $display("FAIL align got %0d want %0d", k % FRAME, pos); end
  endtask

  task automatic do_load(input logic [23:0] v);
    digits_in = v; load = 1'b1; step(); load = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (an !== 6'h3F || bcd_out !== 4'd0 || dp !== 1'b1 || load_ack !== 1'b0 || bcd_err !== 1'b0) begin
      fails++;
      $display("FAIL %s got an=%b bcd=%0d dp=%b ack=%b err=%b want an=111111 bcd=0 dp=1 ack=0 err=0",
               tag, an, bcd_out, dp, load_ack, bcd_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; load = 1'b0; dp_en = 1'b0; digits_in = '0;
    repeat (2) @(posedge clk);
    #3;
    check_reset_values("reset_initial");
    reset = 1'b0;
    model_reset();
    step();
    checks++;
    if (an !== 6'h3F) begin fails++; $display("FAIL first_blank got %b want 111111", an); end
    step();
    checks++;
    if (an !== 6'b111110) begin fails++; $display("FAIL first_drive got %b want 111110", an); end
  endtask

  task automatic test_load_scan();
    logic [3:0] want [6];
    int low_cnt [6];
    int slot;
    want = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    low_cnt = '{0, 0, 0, 0, 0, 0};
    align(10);
    ack_seen = 0;
    do_load(24'h123456);
    align(0);
    for (int i = 0; i < FRAME; i++) begin
      step();
      slot = ((k - 1) / R) % N;
      if ((k - 1) % R == B) begin
        checks++;
        if (bcd_out !== want[slot] || an !== ~(6'd1 << slot)) begin
          fails++;
          $display("FAIL scan_slot%0d got bcd=%0d an=%b want bcd=%0d an=%b", slot, bcd_out, an, want[slot], ~(6'd1 << slot));
        end
      end
      if (an[slot] === 1'b0) low_cnt[slot]++;
    end
    checks++;
    if (ack_seen != 1) begin fails++; $display("FAIL load_ack_count got %0d want 1", ack_seen); end
    for (int s = 0; s < N; s++) begin
      checks++;
      if (low_cnt[s] != R - B) begin fails++; $display("FAIL anode_duty%0d got %0d want %0d", s, low_cnt[s], R - B); end
    end
  endtask

  task automatic test_back_to_back();
    int ones;
    align(3);
    ack_seen = 0;
    do_load(24'h111111);
    repeat (10) step();
    do_load(24'h222222);
    align(0);
    ones = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (an !== 6'h3F && bcd_out === 4'd1) ones++;
    end
    checks++;
    if (ack_seen != 1) begin fails++; $display("FAIL double_load_ack got %0d want 1", ack_seen); end
    checks++;
    if (ones != 0) begin fails++; $display("FAIL stale_digits_shown got %0d want 0", ones); end
  endtask

  task automatic test_dp();
    int low;
    dp_en = 1'b1; low = 0;
    align(0);
    for (int i = 0; i < FRAME; i++) begin step(); if (dp === 1'b0) low++; end
    checks++;
    if (low != 2 * (R - B)) begin fails++; $display("FAIL dp_on_count got %0d want %0d", low, 2 * (R - B)); end
    dp_en = 1'b0; low = 0;
    for (int i = 0; i < FRAME; i++) begin step(); if (dp === 1'b0) low++; end
    checks++;
    if (low != 0) begin fails++; $display("FAIL dp_off_count got %0d want 0", low); end
  endtask

  task automatic test_leading_zero();
    int low5, want5;
    do_load(24'h091530);
    align(0);
    low5 = 0;
    for (int i = 0; i < FRAME; i++) begin step(); if (an[5] === 1'b0) low5++; end
    want5 = LZB ? 0 : R - B;
    checks++;
    if (low5 != want5) begin fails++; $display("FAIL hours_tens_on got %0d want %0d", low5, want5); end
  endtask

  task automatic test_enable();
    align(20);
    ack_seen = 0;
    enable = 1'b0;
    step();
    checks++;
    if (an !== 6'h3F) begin fails++; $display("FAIL disable_an got %b want 111111", an); end
    repeat (2) step();
    do_load(24'h224466);
    repeat (3) step();
    enable = 1'b1;
    step();
    step();
    checks++;
    if (an !== 6'b111110) begin fails++; $display("FAIL reenable_idx0 got %b want 111110", an); end
    align(0);
    repeat (R) step();
    checks++;
    if (ack_seen != 1) begin fails++; $display("FAIL reenable_ack got %0d want 1", ack_seen); end
  endtask

  task automatic test_bad_digit();
    int low3;
    align(1);
    do_load(24'h12A456);
    align(0);
    low3 = 0;
    for (int i = 0; i < FRAME; i++) begin step(); if (an[3] === 1'b0) low3++; end
    checks++;
    if (low3 != 0) begin fails++; $display("FAIL bad_digit_anode got %0d want 0", low3); end
    checks++;
    if (bcd_err !== 1'b1) begin fails++; $display("FAIL bcd_err_set got %b want 1", bcd_err); end
    do_load(24'h123456);
    repeat (2 * FRAME) step();
    checks++;
    if (bcd_err !== 1'b1) begin fails++; $display("FAIL bcd_err_sticky got %b want 1", bcd_err); end
  endtask

  task automatic test_random();
    logic [23:0] v;
    for (int c = 0; c < 1500; c++) begin
      enable = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 15) == 0) dp_en = ~dp_en;
      load = ($urandom_range(0, 29) == 0);
      for (int i = 0; i < N; i++)
        v[4*i +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      digits_in = v;
      step();
    end
    load = 1'b0; enable = 1'b1;
  endtask

  task automatic test_reset_mid_drive();
    do_load(24'h123456);
    align(0);
    align(4);
    #1;
    reset = 1'b1;
    #1;
    check_reset_values("reset_mid_drive");
    @(posedge clk);
    #3;
    reset = 1'b0;
    model_reset();
    step();
    step();
    checks++;
    if (an !== 6'b111110) begin fails++; $display("FAIL post_reset_drive got %b want 111110", an); end
    repeat (2 * FRAME) step();
  endtask

  initial begin
    ack_seen = 0;
    test_reset();
    test_load_scan();
    test_back_to_back();
    test_dp();
    test_leading_zero();
    test_enable();
    test_bad_digit();
    test_random();
    test_reset_mid_drive();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
